// File: rtl/fwd_pkg.sv
// Shared types and constants for the EX-stage operand-forwarding control.
package fwd_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned SEL_W          = 2;

  localparam logic [SEL_W-1:0] FWD_NONE = 2'd0;
  localparam logic [SEL_W-1:0] FWD_MEM  = 2'd1;
  localparam logic [SEL_W-1:0] FWD_EX   = 2'd2;
  localparam logic [SEL_W-1:0] FWD_ID   = 2'd3;

  // One in-flight producer: valid, destination register, is-a-load.
  typedef struct packed {
    logic                      v;
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic                      ld;
  } sb_entry_t;

  // True when an in-flight producer writes the register a consumer actually reads.
  function automatic logic sb_hit(input sb_entry_t e,
                                  input logic [REG_ADDR_W_DEF-1:0] src,
                                  input logic use_src);
    return e.v && use_src && (e.rd == src) && (src != '0);
  endfunction

endpackage

// File: rtl/fwd_match_enc.sv
// One source operand versus the three-deep producer scoreboard: nearest-match
// forwarding code plus a flag for a load producer still too close to forward.
module fwd_match_enc
  import fwd_pkg::*;
#(
  parameter int unsigned LOAD_DIST = 2
) (
  input  sb_entry_t                 p1,
  input  sb_entry_t                 p2,
  input  sb_entry_t                 p3,
  input  logic [REG_ADDR_W_DEF-1:0] src,
  input  logic                      use_src,
  output logic [SEL_W-1:0]          code_c,
  output logic                      too_close_c
);

  // Priority encode: the youngest producer holds the live value.
  always_comb begin
    code_c      = FWD_NONE;
    too_close_c = 1'b0;
    if (sb_hit(p1, src, use_src)) begin
      code_c      = FWD_ID;
      too_close_c = p1.ld && (32'd1 < LOAD_DIST);
    end else if (sb_hit(p2, src, use_src)) begin
      code_c      = FWD_EX;
      too_close_c = p2.ld && (32'd2 < LOAD_DIST);
    end else if (sb_hit(p3, src, use_src)) begin
      code_c      = FWD_MEM;
      too_close_c = p3.ld && (32'd3 < LOAD_DIST);
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall generation for the EX operand muxes.
// Tracks the last three issued destinations and registers per-operand selects
// for the instruction moving from ID into EX.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  // Must equal the package width, which sizes the scoreboard entries.
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned LOAD_DIST  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_use_imm,
  input  logic                  id_is_store,
  input  logic                  id_is_load,
  input  logic                  id_regwrite,
  input  logic                  id_is_jr,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [SEL_W-1:0]      alu_selA,
  output logic [SEL_W-1:0]      alu_selB,
  output logic [SEL_W-1:0]      store_rs2_forward,
  output logic                  ex_is_jr
);

  sb_entry_t        p1_q, p2_q, p3_q;
  sb_entry_t        id_entry_c;
  logic [SEL_W-1:0] rs1_code_c, rs2_code_c;
  logic             rs1_close_c, rs2_close_c;
  logic [SEL_W-1:0] sel_a_c, sel_b_c, sel_st_c;
  logic             bubble_c;

  fwd_match_enc #(.LOAD_DIST(LOAD_DIST)) u_enc_rs1 (
    .p1          (p1_q),
    .p2          (p2_q),
    .p3          (p3_q),
    .src         (REG_ADDR_W_DEF'(id_rs1)),
    .use_src     (id_use_rs1),
    .code_c      (rs1_code_c),
    .too_close_c (rs1_close_c)
  );

  fwd_match_enc #(.LOAD_DIST(LOAD_DIST)) u_enc_rs2 (
    .p1          (p1_q),
    .p2          (p2_q),
    .p3          (p3_q),
    .src         (REG_ADDR_W_DEF'(id_rs2)),
    .use_src     (id_use_rs2),
    .code_c      (rs2_code_c),
    .too_close_c (rs2_close_c)
  );

  // ID-stage entry, select candidates and load-use stall.
  always_comb begin
    id_entry_c    = '0;
    id_entry_c.v  = id_valid && id_regwrite && (id_rd != '0);
    id_entry_c.rd = REG_ADDR_W_DEF'(id_rd);
    id_entry_c.ld = id_is_load;

    sel_a_c  = id_valid ? rs1_code_c : FWD_NONE;
    sel_b_c  = (id_valid && !id_use_imm) ? rs2_code_c : FWD_NONE;
    sel_st_c = (id_valid && id_is_store) ? rs2_code_c : FWD_NONE;

    stall    = id_valid && !flush && (rs1_close_c || rs2_close_c);
    bubble_c = flush || stall;
  end

  // Scoreboard shift and registered EX-side selects; hold freezes everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      p1_q              <= '0;
      p2_q              <= '0;
      p3_q              <= '0;
      ex_valid          <= 1'b0;
      alu_selA          <= FWD_NONE;
      alu_selB          <= FWD_NONE;
      store_rs2_forward <= FWD_NONE;
      ex_is_jr          <= 1'b0;
    end else if (!hold) begin
      p3_q <= p2_q;
      p2_q <= p1_q;
      if (bubble_c) begin
        p1_q              <= '0;
        ex_valid          <= 1'b0;
        alu_selA          <= FWD_NONE;
        alu_selB          <= FWD_NONE;
        store_rs2_forward <= FWD_NONE;
        ex_is_jr          <= 1'b0;
      end else begin
        p1_q              <= id_entry_c;
        ex_valid          <= id_valid;
        alu_selA          <= sel_a_c;
        alu_selB          <= sel_b_c;
        store_rs2_forward <= sel_st_c;
        ex_is_jr          <= id_valid && id_is_jr;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl with hand-computed expectations.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst, hold, flush, id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_use_imm;
  logic       id_is_store, id_is_load, id_regwrite, id_is_jr;
  logic       stall, ex_valid, ex_is_jr;
  logic [1:0] alu_selA, alu_selB, store_rs2_forward;

  int total = 0;
  int bad   = 0;

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_DIST(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .hold              (hold),
    .flush             (flush),
    .id_valid          (id_valid),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .id_rd             (id_rd),
    .id_use_rs1        (id_use_rs1),
    .id_use_rs2        (id_use_rs2),
    .id_use_imm        (id_use_imm),
    .id_is_store       (id_is_store),
    .id_is_load        (id_is_load),
    .id_regwrite       (id_regwrite),
    .id_is_jr          (id_is_jr),
    .stall             (stall),
    .ex_valid          (ex_valid),
    .alu_selA          (alu_selA),
    .alu_selB          (alu_selB),
    .store_rs2_forward (store_rs2_forward),
    .ex_is_jr          (ex_is_jr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_id();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_use_imm = 0;
    id_is_store = 0; id_is_load = 0; id_regwrite = 0; id_is_jr = 0;
  endtask

  task automatic op_alu(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    clr_id();
    id_valid = 1; id_rd = rd; id_rs1 = a; id_rs2 = b;
    id_use_rs1 = 1; id_use_rs2 = 1; id_regwrite = 1;
  endtask

  task automatic op_addi(input logic [4:0] rd, input logic [4:0] a);
    clr_id();
    id_valid = 1; id_rd = rd; id_rs1 = a;
    id_use_rs1 = 1; id_use_imm = 1; id_regwrite = 1;
  endtask

  task automatic op_load(input logic [4:0] rd, input logic [4:0] a);
    op_addi(rd, a);
    id_is_load = 1;
  endtask

  task automatic op_store(input logic [4:0] base, input logic [4:0] data);
    clr_id();
    id_valid = 1; id_rs1 = base; id_rs2 = data;
    id_use_rs1 = 1; id_use_rs2 = 1; id_use_imm = 1; id_is_store = 1;
  endtask

  task automatic op_jr(input logic [4:0] a);
    clr_id();
    id_valid = 1; id_rs1 = a; id_use_rs1 = 1; id_use_imm = 1; id_is_jr = 1;
  endtask

  initial begin
    rst = 0; hold = 0; flush = 0;
    clr_id();
    step();
    step();
    check("rst_ex_valid", ex_valid, 0);
    check("rst_selA", alu_selA, 0);
    check("rst_selB", alu_selB, 0);
    check("rst_st", store_rs2_forward, 0);
    check("rst_stall", stall, 0);
    rst = 1;

    // Back-to-back ALU dependency: x5 forwarded from P1.
    op_alu(5, 1, 2);
    #1 check("b2b_p_stall", stall, 0);
    step();
    check("b2b_p_valid", ex_valid, 1);
    check("b2b_p_selA", alu_selA, 0);
    op_alu(6, 5, 3);
    #1 check("b2b_c_stall", stall, 0);
    step();
    check("b2b_c_valid", ex_valid, 1);
    check("b2b_c_selA", alu_selA, 3);
    check("b2b_c_selB", alu_selB, 0);

    // Producer three slots back: rs2 from mem_haz.
    op_alu(5, 1, 2);   step();
    op_alu(12, 13, 14); step();
    op_alu(15, 16, 17); step();
    op_alu(7, 4, 5);
    #1 check("p3_stall", stall, 0);
    step();
    check("p3_selA", alu_selA, 0);
    check("p3_selB", alu_selB, 1);

    // Load-use: one-cycle stall, bubble, then both operands from ex_haz.
    op_load(8, 20); step();
    op_alu(9, 8, 8);
    #1 check("lu_stall1", stall, 1);
    step();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_selA", alu_selA, 0);
    check("lu_stall2", stall, 0);
    step();
    check("lu_valid", ex_valid, 1);
    check("lu_selA", alu_selA, 2);
    check("lu_selB", alu_selB, 2);

    // Store data forwarded from P1; base register independent.
    op_alu(10, 1, 2); step();
    op_store(11, 10);
    #1 check("st_stall", stall, 0);
    step();
    check("st_fwd", store_rs2_forward, 3);
    check("st_selB", alu_selB, 0);
    check("st_selA", alu_selA, 0);

    // x0 destination never forwards.
    op_addi(0, 1); step();
    op_alu(21, 0, 0); step();
    check("x0_selA", alu_selA, 0);
    check("x0_selB", alu_selB, 0);

    // Flush with a too-close load consumer in ID: no stall, bubble issued.
    op_load(8, 20); step();
    op_alu(9, 8, 3);
    flush = 1;
    #1 check("fl_stall", stall, 0);
    step();
    flush = 0;
    check("fl_valid", ex_valid, 0);
    check("fl_selA", alu_selA, 0);
    check("fl_jr", ex_is_jr, 0);
    op_alu(9, 8, 3);
    #1 check("fl_after_stall", stall, 0);
    step();
    check("fl_after_selA", alu_selA, 2);
    check("fl_after_valid", ex_valid, 1);

    // jr reads rs1 through the forwarding path.
    op_alu(22, 1, 2); step();
    op_jr(22); step();
    check("jr_selA", alu_selA, 3);
    check("jr_flag", ex_is_jr, 1);
    check("jr_selB", alu_selB, 0);

    // Hold during a stall freezes outputs, then reset clears everything.
    op_load(8, 20); step();
    check("hd_ld_valid", ex_valid, 1);
    op_alu(9, 8, 8);
    #1 check("hd_stall0", stall, 1);
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hd_valid", ex_valid, 1);
      check("hd_selA", alu_selA, 0);
      check("hd_stall", stall, 1);
    end
    hold = 0;
    rst = 0;
    step();
    rst = 1;
    #1;
    check("hr_valid", ex_valid, 0);
    check("hr_selA", alu_selA, 0);
    check("hr_selB", alu_selB, 0);
    check("hr_st", store_rs2_forward, 0);
    check("hr_stall", stall, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
